// File: rtl/mii_gen_check_if.sv
// Bus bundle for the MII traffic generator/checker: error-injection
// requests in, the 64-bit MII word stream and sticky error flags out.
interface mii_gen_check_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic                  i_inj_payload;
    logic                  i_inj_ifg;
    logic                  i_inj_ctrl;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic [CTRL_WIDTH-1:0] o_tx_ctrl;
    logic                  payload_error;
    logic                  intergap_error;
    logic                  other_error;

    // The traffic block itself: takes injection requests, drives the stream.
    modport master (
        input  i_inj_payload,
        input  i_inj_ifg,
        input  i_inj_ctrl,
        output o_tx_data,
        output o_tx_ctrl,
        output payload_error,
        output intergap_error,
        output other_error
    );

    // Whoever controls injections and observes the stream and flags.
    modport slave (
        output i_inj_payload,
        output i_inj_ifg,
        output i_inj_ctrl,
        input  o_tx_data,
        input  o_tx_ctrl,
        input  payload_error,
        input  intergap_error,
        input  other_error
    );
endinterface

// File: rtl/mii_gen_check.sv
// Self-checking MII traffic block: a frame generator (gap, start,
// counting payload, terminate) plus a monitor that watches the generated
// stream and raises sticky payload / inter-frame-gap / protocol flags.
module mii_gen_check #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         CTRL_WIDTH    = 8,
    parameter logic [7:0] IDLE_CODE     = 8'h07,
    parameter logic [7:0] START_CODE    = 8'hFB,
    parameter logic [7:0] TERM_CODE     = 8'hFD,
    parameter int         PAYLOAD_WORDS = 8,
    parameter int         IFG_WORDS     = 3,
    parameter int         MIN_IFG_WORDS = 2
) (
    input  logic             clk,
    input  logic             i_rst,
    mii_gen_check_if.master  mii
);

    // One control bit per byte lane, so the lane count follows CTRL_WIDTH.
    localparam int         LANES         = CTRL_WIDTH;
    localparam logic [7:0] INJ_CTRL_CODE = 8'hAA;
    localparam logic [7:0] IFG_LAST      = 8'(IFG_WORDS - 1);
    localparam logic [7:0] PAY_LAST      = 8'(PAYLOAD_WORDS - 1);
    localparam logic [7:0] PAY_COUNT     = 8'(PAYLOAD_WORDS);
    localparam logic [7:0] MIN_IFG       = 8'(MIN_IFG_WORDS);

    typedef enum logic [1:0] {
        GAP,
        START,
        PAYLOAD,
        TERM
    } gen_state_t;

    gen_state_t            gen_state;
    logic [7:0]            gap_cnt;
    logic [7:0]            word_idx;
    logic                  lat_payload;
    logic                  lat_ifg;
    logic                  lat_ctrl;
    logic                  frame_inj_payload;
    logic                  frame_inj_ctrl;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [CTRL_WIDTH-1:0] tx_ctrl_q;

    logic                  inj_payload_eff;
    logic                  inj_ifg_eff;
    logic                  inj_ctrl_eff;
    logic [7:0]            gap_end;

    logic                  mon_in_frame;
    logic [7:0]            mon_word_cnt;
    logic [7:0]            mon_gap_cnt;
    logic                  payload_error_q;
    logic                  intergap_error_q;
    logic                  other_error_q;

    logic                  mon_start;
    logic                  mon_term;
    logic                  mon_idle_word;
    logic                  mon_data_any;
    logic                  mon_bad_ctrl;
    logic                  mon_start_lane;
    logic                  mon_preamble_bad;
    logic                  mon_mismatch;

    function automatic logic [DATA_WIDTH-1:0] fill_word(input logic [7:0] code);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) d[8*k +: 8] = code;
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] start_word();
        logic [DATA_WIDTH-1:0] d;
        d = fill_word(8'h55);
        d[8*(LANES-1) +: 8] = 8'hD5;
        d[7:0] = START_CODE;
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] term_word();
        logic [DATA_WIDTH-1:0] d;
        d = fill_word(IDLE_CODE);
        d[7:0] = TERM_CODE;
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] payload_data(input logic [7:0] w,
                                                           input logic inj_pay,
                                                           input logic inj_ctl);
        logic [DATA_WIDTH-1:0] d;
        logic [7:0]            base;
        d = '0;
        base = {w[4:0], 3'b000};
        for (int k = 0; k < LANES; k++) d[8*k +: 8] = base + 8'(k);
        if (inj_pay && w == 8'd0) d[7:0] = d[7:0] ^ 8'hFF;
        if (inj_ctl && w == 8'd1) d[8*3 +: 8] = INJ_CTRL_CODE;
        return d;
    endfunction

    function automatic logic [CTRL_WIDTH-1:0] payload_ctrl(input logic [7:0] w,
                                                           input logic inj_ctl);
        logic [CTRL_WIDTH-1:0] c;
        c = '0;
        if (inj_ctl && w == 8'd1) c[3] = 1'b1;
        return c;
    endfunction

    // A request arriving on the same edge a frame starts still applies to it.
    assign inj_payload_eff = lat_payload | mii.i_inj_payload;
    assign inj_ifg_eff     = lat_ifg | mii.i_inj_ifg;
    assign inj_ctrl_eff    = lat_ctrl | mii.i_inj_ctrl;
    assign gap_end         = inj_ifg_eff ? 8'd0 : IFG_LAST;

    // Generator: gap_cnt indexes the idle word currently on the output, so
    // the idle word shown during reset counts as the first gap word.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            gen_state         <= GAP;
            gap_cnt           <= 8'd0;
            word_idx          <= 8'd0;
            lat_payload       <= 1'b0;
            lat_ifg           <= 1'b0;
            lat_ctrl          <= 1'b0;
            frame_inj_payload <= 1'b0;
            frame_inj_ctrl    <= 1'b0;
            tx_data_q         <= fill_word(IDLE_CODE);
            tx_ctrl_q         <= '1;
        end else begin
            lat_payload <= inj_payload_eff;
            lat_ifg     <= inj_ifg_eff;
            lat_ctrl    <= inj_ctrl_eff;
            case (gen_state)
                GAP: begin
                    if (gap_cnt >= gap_end) begin
                        gen_state         <= START;
                        tx_data_q         <= start_word();
                        tx_ctrl_q         <= CTRL_WIDTH'(1);
                        frame_inj_payload <= inj_payload_eff;
                        frame_inj_ctrl    <= inj_ctrl_eff;
                        lat_payload       <= 1'b0;
                        lat_ifg           <= 1'b0;
                        lat_ctrl          <= 1'b0;
                    end else begin
                        gap_cnt   <= gap_cnt + 8'd1;
                        tx_data_q <= fill_word(IDLE_CODE);
                        tx_ctrl_q <= '1;
                    end
                end
                START: begin
                    gen_state <= PAYLOAD;
                    word_idx  <= 8'd0;
                    tx_data_q <= payload_data(8'd0, frame_inj_payload, frame_inj_ctrl);
                    tx_ctrl_q <= payload_ctrl(8'd0, frame_inj_ctrl);
                end
                PAYLOAD: begin
                    if (word_idx == PAY_LAST) begin
                        gen_state <= TERM;
                        tx_data_q <= term_word();
                        tx_ctrl_q <= '1;
                    end else begin
                        word_idx  <= word_idx + 8'd1;
                        tx_data_q <= payload_data(word_idx + 8'd1, frame_inj_payload,
                                                  frame_inj_ctrl);
                        tx_ctrl_q <= payload_ctrl(word_idx + 8'd1, frame_inj_ctrl);
                    end
                end
                TERM: begin
                    gen_state <= GAP;
                    gap_cnt   <= 8'd0;
                    tx_data_q <= fill_word(IDLE_CODE);
                    tx_ctrl_q <= '1;
                end
                default: begin
                    gen_state <= GAP;
                    gap_cnt   <= 8'd0;
                    tx_data_q <= fill_word(IDLE_CODE);
                    tx_ctrl_q <= '1;
                end
            endcase
        end
    end

    // Monitor word classification: decode the word currently on the output.
    always_comb begin
        logic [7:0] lane;
        logic [7:0] base;
        lane             = 8'd0;
        base             = {mon_word_cnt[4:0], 3'b000};
        mon_idle_word    = 1'b1;
        mon_data_any     = 1'b0;
        mon_bad_ctrl     = 1'b0;
        mon_start_lane   = 1'b0;
        mon_preamble_bad = 1'b0;
        mon_mismatch     = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane = tx_data_q[8*k +: 8];
            if (tx_ctrl_q[k]) begin
                if (lane != IDLE_CODE && lane != START_CODE && lane != TERM_CODE)
                    mon_bad_ctrl = 1'b1;
                if (k != 0 && lane == START_CODE) mon_start_lane = 1'b1;
                if (lane != IDLE_CODE) mon_idle_word = 1'b0;
            end else begin
                mon_data_any  = 1'b1;
                mon_idle_word = 1'b0;
                if (lane != base + 8'(k)) mon_mismatch = 1'b1;
            end
            if (k != 0) begin
                if (tx_ctrl_q[k] || lane != ((k == LANES - 1) ? 8'hD5 : 8'h55))
                    mon_preamble_bad = 1'b1;
            end
        end
        mon_start = tx_ctrl_q[0] && tx_data_q[7:0] == START_CODE;
        mon_term  = tx_ctrl_q[0] && tx_data_q[7:0] == TERM_CODE;
    end

    // Monitor state and sticky flags; the gap counter starts preset so the
    // first frame after reset is never reported as a short gap.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mon_in_frame     <= 1'b0;
            mon_word_cnt     <= 8'd0;
            mon_gap_cnt      <= MIN_IFG;
            payload_error_q  <= 1'b0;
            intergap_error_q <= 1'b0;
            other_error_q    <= 1'b0;
        end else begin
            if (mon_bad_ctrl || mon_start_lane) other_error_q <= 1'b1;
            if (mon_start) begin
                if (mon_in_frame || mon_preamble_bad) other_error_q <= 1'b1;
                if (!mon_in_frame && mon_gap_cnt < MIN_IFG) intergap_error_q <= 1'b1;
                mon_in_frame <= 1'b1;
                mon_word_cnt <= 8'd0;
            end else if (mon_term) begin
                if (!mon_in_frame) other_error_q <= 1'b1;
                mon_in_frame <= 1'b0;
                mon_gap_cnt  <= 8'd0;
            end else if (mon_in_frame) begin
                if (mon_mismatch) payload_error_q <= 1'b1;
                if (mon_word_cnt >= PAY_COUNT) other_error_q <= 1'b1;
                if (mon_word_cnt != 8'hFF) mon_word_cnt <= mon_word_cnt + 8'd1;
            end else begin
                if (mon_data_any) other_error_q <= 1'b1;
                if (mon_idle_word && mon_gap_cnt != 8'hFF)
                    mon_gap_cnt <= mon_gap_cnt + 8'd1;
            end
        end
    end

    assign mii.o_tx_data      = tx_data_q;
    assign mii.o_tx_ctrl      = tx_ctrl_q;
    assign mii.payload_error  = payload_error_q;
    assign mii.intergap_error = intergap_error_q;
    assign mii.other_error    = other_error_q;

endmodule

// File: tb/tb_mii_gen_check.sv
// Bench for mii_gen_check: a frame-level reference model queues the word
// and flag state expected each cycle; a monitor pops and compares.
module tb_mii_gen_check;

    localparam int          IFG_WORDS     = 3;
    localparam int          MIN_IFG_WORDS = 2;
    localparam int          PAYLOAD_WORDS = 8;
    localparam logic [63:0] IDLE_WORD     = 64'h0707070707070707;
    localparam logic [63:0] START_WORD    = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD     = 64'h07070707070707FD;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mii_gen_check_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) mii ();

    mii_gen_check #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .IDLE_CODE(8'h07), .START_CODE(8'hFB),
        .TERM_CODE(8'hFD), .PAYLOAD_WORDS(PAYLOAD_WORDS), .IFG_WORDS(IFG_WORDS),
        .MIN_IFG_WORDS(MIN_IFG_WORDS)
    ) dut (
        .clk(clk),
        .i_rst(rst),
        .mii(mii)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        bit          c_pe;
        bit          c_ie;
        bit          c_oe;
    } word_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic [2:0]  flags;
    } exp_t;

    word_t frame_q[$];
    exp_t  exp_q[$];

    int idle_run;
    bit after_reset;
    bit pend_pay, pend_ifg, pend_ctrl;
    bit st_pe, st_ie, st_oe;

    function automatic word_t makeWord(input logic [63:0] d, input logic [7:0] c);
        word_t w;
        w.data = d;
        w.ctrl = c;
        w.c_pe = 1'b0;
        w.c_ie = 1'b0;
        w.c_oe = 1'b0;
        return w;
    endfunction

    // Queue the payload words and terminate of one frame, with any injections.
    task automatic buildFrame(input bit inj_pay, input bit inj_ctrl);
        word_t w;
        for (int wi = 0; wi < PAYLOAD_WORDS; wi++) begin
            w = makeWord(64'd0, 8'h00);
            for (int k = 0; k < 8; k++) w.data[8*k +: 8] = 8'((8 * wi + k) % 256);
            if (inj_pay && wi == 0) begin
                w.data[7:0] = w.data[7:0] ^ 8'hFF;
                w.c_pe = 1'b1;
            end
            if (inj_ctrl && wi == 1) begin
                w.data[31:24] = 8'hAA;
                w.ctrl[3] = 1'b1;
                w.c_oe = 1'b1;
            end
            frame_q.push_back(w);
        end
        frame_q.push_back(makeWord(TERM_WORD, 8'hFF));
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: decides the next word from gap length, pending
    // injections and the frame still being sent, and tracks expected flags.
    always @(posedge clk) begin : ref_model
        word_t w;
        exp_t  e;
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            idle_run    = 1;
            after_reset = 1'b1;
            pend_pay    = 1'b0;
            pend_ifg    = 1'b0;
            pend_ctrl   = 1'b0;
            st_pe       = 1'b0;
            st_ie       = 1'b0;
            st_oe       = 1'b0;
        end else begin
            pend_pay  = pend_pay  | mii.i_inj_payload;
            pend_ifg  = pend_ifg  | mii.i_inj_ifg;
            pend_ctrl = pend_ctrl | mii.i_inj_ctrl;
            if (frame_q.size() > 0) begin
                w = frame_q.pop_front();
            end else if (idle_run >= (pend_ifg ? 1 : IFG_WORDS)) begin
                w = makeWord(START_WORD, 8'h01);
                w.c_ie = !after_reset && (idle_run < MIN_IFG_WORDS);
                buildFrame(pend_pay, pend_ctrl);
                pend_pay    = 1'b0;
                pend_ifg    = 1'b0;
                pend_ctrl   = 1'b0;
                idle_run    = 0;
                after_reset = 1'b0;
            end else begin
                w = makeWord(IDLE_WORD, 8'hFF);
                idle_run++;
            end
            e.data  = w.data;
            e.ctrl  = w.ctrl;
            e.flags = {st_pe, st_ie, st_oe};
            exp_q.push_back(e);
            st_pe = st_pe | w.c_pe;
            st_ie = st_ie | w.c_ie;
            st_oe = st_oe | w.c_oe;
        end
    end

    // Monitor: on the falling edge compare the DUT against the next expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            checkOutput("reset_data", mii.o_tx_data, IDLE_WORD);
            checkOutput("reset_ctrl", {56'd0, mii.o_tx_ctrl}, 64'hFF);
            checkOutput("reset_flags",
                        {61'd0, mii.payload_error, mii.intergap_error, mii.other_error},
                        64'd0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL queue_underrun: got no expectation, expected one at %0t",
                     $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("tx_data", mii.o_tx_data, e.data);
            checkOutput("tx_ctrl", {56'd0, mii.o_tx_ctrl}, {56'd0, e.ctrl});
            checkOutput("flags{pay,ifg,other}",
                        {61'd0, mii.payload_error, mii.intergap_error, mii.other_error},
                        {61'd0, e.flags});
        end
    end

    // Drive one cycle of reset and injection inputs, just after the falling edge.
    task automatic applyStimulus(input bit r, input bit p, input bit g, input bit c);
        @(negedge clk);
        #1;
        rst               = r;
        mii.i_inj_payload = p;
        mii.i_inj_ifg     = g;
        mii.i_inj_ctrl    = c;
    endtask

    task automatic runCycles(input int n, input int pct);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, $urandom_range(0, 99) < pct,
                          $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
    endtask

    task automatic resetPulse(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst               = 1'b1;
        mii.i_inj_payload = 1'b0;
        mii.i_inj_ifg     = 1'b0;
        mii.i_inj_ctrl    = 1'b0;
        $display("[TB] clean traffic");
        resetPulse(1);
        runCycles(200, 0);

        $display("[TB] payload injection");
        resetPulse(2);
        runCycles(20, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runCycles(30, 0);

        $display("[TB] gap injection");
        resetPulse(2);
        runCycles(20, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runCycles(30, 0);

        $display("[TB] control injection");
        resetPulse(2);
        runCycles(20, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        runCycles(30, 0);

        $display("[TB] reset mid-payload");
        resetPulse(2);
        runCycles(6, 0);
        resetPulse(2);
        runCycles(40, 0);

        $display("[TB] random injections");
        resetPulse(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) resetPulse(2);
            else runCycles(1, 3);
        end
        runCycles(20, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
